// File: rtl/mult_rr_scheduler.sv
// Round-robin scheduler that time-shares one 4x4 array multiplier among NREQ requesters.
// Operands and product are registered around the multiplier; responses are tagged with the id.

module array_multiplier #(
    parameter int unsigned W = 4
) (
    input  logic [W-1:0]   i_a,
    input  logic [W-1:0]   i_b,
    output logic [2*W-1:0] o_p
);

    logic [W:0]   w_acc;
    logic [W:0]   w_row;
    logic         w_carry;
    logic         w_pp;
    logic [2*W-1:0] w_p;

    // Shift-and-add array: each row adds one partial product into the running sum,
    // retiring the lowest bit of the sum as a product bit.
    always_comb begin
        w_acc   = '0;
        w_row   = '0;
        w_carry = 1'b0;
        w_pp    = 1'b0;
        w_p     = '0;
        for (int j = 0; j < W; j++) begin
            w_acc[j] = i_a[j] & i_b[0];
        end
        w_p[0] = w_acc[0];
        for (int i = 1; i < W; i++) begin
            w_carry = 1'b0;
            for (int j = 0; j < W; j++) begin
                w_pp     = i_a[j] & i_b[i];
                w_row[j] = w_acc[j+1] ^ w_pp ^ w_carry;
                w_carry  = (w_acc[j+1] & w_pp) | (w_acc[j+1] & w_carry) | (w_pp & w_carry);
            end
            w_row[W] = w_carry;
            w_p[i]   = w_row[0];
            w_acc    = w_row;
        end
        w_p[2*W-1:W] = w_acc[W:1];
    end

    assign o_p = w_p;

endmodule

module mult_rr_scheduler #(
    parameter int unsigned NREQ = 4,
    parameter int unsigned W    = 4,
    parameter int unsigned IDW  = $clog2(NREQ)
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic [NREQ-1:0]   i_req_valid,
    input  logic [NREQ*W-1:0] i_req_a,
    input  logic [NREQ*W-1:0] i_req_b,
    output logic [NREQ-1:0]   o_req_ready,
    output logic              o_rsp_valid,
    output logic [IDW-1:0]    o_rsp_id,
    output logic [2*W-1:0]    o_rsp_p,
    input  logic              i_rsp_ready,
    output logic              o_busy
);

    if (W != 4) begin : g_w_check
        $error("mult_rr_scheduler: W must be 4 to match array_multiplier");
    end
    if (NREQ < 2 || NREQ > 8) begin : g_nreq_check
        $error("mult_rr_scheduler: NREQ must be in 2..8");
    end
    if (IDW != $clog2(NREQ)) begin : g_idw_check
        $error("mult_rr_scheduler: IDW must equal $clog2(NREQ)");
    end

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StCalc = 2'd1,
        StResp = 2'd2
    } state_e;

    state_e         r_state;
    state_e         w_state_next;

    logic [W-1:0]   r_a;
    logic [W-1:0]   r_b;
    logic [IDW-1:0] r_id;
    logic [IDW-1:0] r_last_grant;
    logic [2*W-1:0] r_p;

    logic [NREQ-1:0] w_grant_oh;
    logic [IDW-1:0]  w_grant_id;
    logic [IDW-1:0]  w_idx;
    logic            w_found;
    logic [W-1:0]    w_sel_a;
    logic [W-1:0]    w_sel_b;
    logic            w_xfer;
    logic [2*W-1:0]  w_prod;

    // Search starts just after the last winner so every lane gets a turn within NREQ grants.
    always_comb begin
        w_grant_oh = '0;
        w_grant_id = '0;
        w_idx      = '0;
        w_found    = 1'b0;
        for (int k = 1; k <= int'(NREQ); k++) begin
            w_idx = IDW'((int'(r_last_grant) + k) % int'(NREQ));
            if (!w_found && i_req_valid[w_idx]) begin
                w_found           = 1'b1;
                w_grant_id        = w_idx;
                w_grant_oh[w_idx] = 1'b1;
            end
        end
    end

    always_comb begin
        w_sel_a = '0;
        w_sel_b = '0;
        for (int i = 0; i < int'(NREQ); i++) begin
            if (w_grant_oh[i]) begin
                w_sel_a = i_req_a[i*W +: W];
                w_sel_b = i_req_b[i*W +: W];
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_xfer       = 1'b0;
        o_req_ready  = '0;
        o_rsp_valid  = 1'b0;
        o_busy       = 1'b1;
        unique case (r_state)
            StIdle: begin
                o_busy = 1'b0;
                if (!i_rst) begin
                    o_req_ready = w_grant_oh;
                    w_xfer      = w_found;
                end
                if (w_xfer) begin
                    w_state_next = StCalc;
                end
            end
            StCalc: begin
                w_state_next = StResp;
            end
            StResp: begin
                o_rsp_valid = 1'b1;
                if (i_rsp_ready) begin
                    w_state_next = StIdle;
                end
            end
            default: begin
                w_state_next = StIdle;
            end
        endcase
    end

    array_multiplier #(
        .W (W)
    ) u_mult (
        .i_a (r_a),
        .i_b (r_b),
        .o_p (w_prod)
    );

    // Product register is only written in CALC, so it holds the last result after RESP.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_a          <= '0;
            r_b          <= '0;
            r_id         <= '0;
            r_p          <= '0;
            r_last_grant <= IDW'(NREQ - 1);
        end else begin
            if (w_xfer) begin
                r_a          <= w_sel_a;
                r_b          <= w_sel_b;
                r_id         <= w_grant_id;
                r_last_grant <= w_grant_id;
            end
            if (r_state == StCalc) begin
                r_p <= w_prod;
            end
        end
    end

    assign o_rsp_id = r_id;
    assign o_rsp_p  = r_p;

endmodule

// File: tb/tb_mult_rr_scheduler.sv
// Self-checking bench for mult_rr_scheduler: scenario tasks plus a cycle model that
// predicts grants and queues expected responses for comparison at the response handshake.

module tb_mult_rr_scheduler;

    localparam int NREQ = 4;
    localparam int W    = 4;
    localparam int IDW  = 2;

    logic              clk = 1'b0;
    logic              rst;
    logic [NREQ-1:0]   req_valid;
    logic [NREQ*W-1:0] req_a;
    logic [NREQ*W-1:0] req_b;
    logic [NREQ-1:0]   req_ready;
    logic              rsp_valid;
    logic [IDW-1:0]    rsp_id;
    logic [2*W-1:0]    rsp_p;
    logic              rsp_ready;
    logic              busy;

    int n_vec  = 0;
    int n_miss = 0;

    logic [IDW-1:0] q_id[$];
    logic [2*W-1:0] q_p[$];

    int              m_state = 0;
    int              m_last  = NREQ - 1;
    int              m_g;
    int              m_idx;
    logic [NREQ-1:0] m_exp_rdy;
    logic [2*W-1:0]  m_ea;
    logic [2*W-1:0]  m_eb;

    always #5 clk = ~clk;

    mult_rr_scheduler #(
        .NREQ (NREQ),
        .W    (W),
        .IDW  (IDW)
    ) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_req_valid (req_valid),
        .i_req_a     (req_a),
        .i_req_b     (req_b),
        .o_req_ready (req_ready),
        .o_rsp_valid (rsp_valid),
        .o_rsp_id    (rsp_id),
        .o_rsp_p     (rsp_p),
        .i_rsp_ready (rsp_ready),
        .o_busy      (busy)
    );

    // Reference model: m_state 0=idle, 1=calc, 2=resp; updated for the coming edge.
    always @(negedge clk) begin
        if (rst) begin
            n_vec++;
            if (req_ready !== '0) begin
                n_miss++;
                $display("FAIL ready_in_reset: got %b want 0000", req_ready);
            end
            m_state = 0;
            m_last  = NREQ - 1;
            q_id.delete();
            q_p.delete();
        end else begin
            m_exp_rdy = '0;
            m_g       = -1;
            if (m_state == 0) begin
                for (int k = 1; k <= NREQ; k++) begin
                    m_idx = (m_last + k) % NREQ;
                    if (m_g < 0 && req_valid[m_idx]) m_g = m_idx;
                end
            end
            for (int i = 0; i < NREQ; i++) begin
                if (i == m_g) begin
                    m_exp_rdy[i] = 1'b1;
                    m_ea = {4'b0, req_a[i*W +: W]};
                    m_eb = {4'b0, req_b[i*W +: W]};
                end
            end
            n_vec++;
            if (req_ready !== m_exp_rdy) begin
                n_miss++;
                $display("FAIL model_ready: got %b want %b", req_ready, m_exp_rdy);
            end
            n_vec++;
            if (busy !== (m_state != 0)) begin
                n_miss++;
                $display("FAIL model_busy: got %b want %b", busy, m_state != 0);
            end
            if (m_state == 2) begin
                n_vec++;
                if (q_id.size() == 0) begin
                    n_miss++;
                    $display("FAIL rsp_unexpected: got id %0d p %0d want no response", rsp_id, rsp_p);
                end else if (rsp_valid !== 1'b1 || rsp_id !== q_id[0] || rsp_p !== q_p[0]) begin
                    n_miss++;
                    $display("FAIL rsp_scoreboard: got v%b id %0d p %0d want v1 id %0d p %0d",
                             rsp_valid, rsp_id, rsp_p, q_id[0], q_p[0]);
                end
                if (rsp_ready) begin
                    if (q_id.size() != 0) begin
                        void'(q_id.pop_front());
                        void'(q_p.pop_front());
                    end
                    m_state = 0;
                end
            end else begin
                n_vec++;
                if (rsp_valid !== 1'b0) begin
                    n_miss++;
                    $display("FAIL rsp_valid_idle: got %b want 0 (model state %0d)", rsp_valid, m_state);
                end
                if (m_state == 1) begin
                    m_state = 2;
                end else if (m_g >= 0) begin
                    q_id.push_back(IDW'(m_g));
                    q_p.push_back(m_ea * m_eb);
                    m_last  = m_g;
                    m_state = 1;
                end
            end
        end
    end

    task automatic do_reset();
        @(posedge clk); #1;
        rst       = 1'b1;
        req_valid = '0;
        rsp_ready = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        req_valid = '1;
        req_a     = '0;
        req_b     = '0;
        rsp_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_vec++;
        if (rsp_valid !== 1'b0) begin n_miss++; $display("FAIL reset_rsp_valid: got %b want 0", rsp_valid); end
        n_vec++;
        if (rsp_id !== '0) begin n_miss++; $display("FAIL reset_rsp_id: got %0d want 0", rsp_id); end
        n_vec++;
        if (rsp_p !== '0) begin n_miss++; $display("FAIL reset_rsp_p: got %0d want 0", rsp_p); end
        n_vec++;
        if (busy !== 1'b0) begin n_miss++; $display("FAIL reset_busy: got %b want 0", busy); end
        @(posedge clk); #1;
        rst       = 1'b0;
        req_valid = '0;
    endtask

    task automatic test_single();
        rsp_ready      = 1'b1;
        req_valid      = 4'b0100;
        req_a          = '0;
        req_b          = '0;
        req_a[2*W +: W] = 4'd3;
        req_b[2*W +: W] = 4'd5;
        @(negedge clk);
        n_vec++;
        if (req_ready !== 4'b0100) begin n_miss++; $display("FAIL single_ready: got %b want 0100", req_ready); end
        @(posedge clk); #1;
        req_valid = '0;
        @(negedge clk);
        n_vec++;
        if (rsp_valid !== 1'b0 || busy !== 1'b1) begin
            n_miss++; $display("FAIL single_calc: got v%b busy%b want v0 busy1", rsp_valid, busy);
        end
        @(posedge clk);
        @(negedge clk);
        n_vec++;
        if (rsp_valid !== 1'b1 || rsp_id !== 2'd2 || rsp_p !== 8'd15) begin
            n_miss++;
            $display("FAIL single_rsp: got v%b id %0d p %0d want v1 id 2 p 15", rsp_valid, rsp_id, rsp_p);
        end
        @(posedge clk);
        @(negedge clk);
        n_vec++;
        if (rsp_valid !== 1'b0) begin n_miss++; $display("FAIL single_rsp_len: got %b want 0", rsp_valid); end
    endtask

    task automatic test_back_to_back();
        int grants   = 0;
        int cyc      = 0;
        int last_cyc = 0;
        int gid;
        do_reset();
        rsp_ready = 1'b1;
        for (int i = 0; i < NREQ; i++) begin
            req_a[i*W +: W] = 4'(i + 1);
            req_b[i*W +: W] = 4'(i + 9);
        end
        req_valid = '1;
        while (grants < 6 && cyc < 40) begin
            @(negedge clk);
            if (req_ready != '0) begin
                gid = -1;
                for (int i = 0; i < NREQ; i++) if (req_ready[i]) gid = i;
                n_vec++;
                if (gid !== grants % NREQ) begin
                    n_miss++; $display("FAIL b2b_order: got %0d want %0d", gid, grants % NREQ);
                end
                if (grants > 0) begin
                    n_vec++;
                    if (cyc - last_cyc !== 3) begin
                        n_miss++; $display("FAIL b2b_spacing: got %0d want 3", cyc - last_cyc);
                    end
                end
                last_cyc = cyc;
                grants++;
            end
            cyc++;
            @(posedge clk); #1;
        end
        n_vec++;
        if (grants !== 6) begin n_miss++; $display("FAIL b2b_timeout: got %0d grants want 6", grants); end
        req_valid = '0;
    endtask

    task automatic test_hold();
        do_reset();
        rsp_ready  = 1'b0;
        req_a[0 +: W] = 4'd15;
        req_b[0 +: W] = 4'd15;
        req_valid  = 4'b0001;
        @(negedge clk);
        n_vec++;
        if (req_ready !== 4'b0001) begin n_miss++; $display("FAIL hold_ready: got %b want 0001", req_ready); end
        @(posedge clk); #1;
        req_valid = 4'b1110;
        @(posedge clk);
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            n_vec++;
            if (rsp_valid !== 1'b1 || rsp_p !== 8'd225 || rsp_id !== 2'd0 || busy !== 1'b1 ||
                req_ready !== 4'b0000) begin
                n_miss++;
                $display("FAIL hold_cycle%0d: got v%b p %0d id %0d busy%b rdy %b want v1 p 225 id 0 busy1 rdy 0000",
                         c, rsp_valid, rsp_p, rsp_id, busy, req_ready);
            end
            @(posedge clk); #1;
            if (c == 4) rsp_ready = 1'b1;
            if (c == 5) req_valid = '0;
        end
        @(negedge clk);
        n_vec++;
        if (rsp_valid !== 1'b0 || rsp_p !== 8'd225) begin
            n_miss++; $display("FAIL hold_after: got v%b p %0d want v0 p 225", rsp_valid, rsp_p);
        end
    endtask

    task automatic test_rst_calc();
        @(posedge clk); #1;
        req_a[0 +: W] = 4'd7;
        req_b[0 +: W] = 4'd9;
        req_valid     = 4'b0001;
        @(negedge clk);
        n_vec++;
        if (req_ready !== 4'b0001) begin n_miss++; $display("FAIL rstcalc_ready: got %b want 0001", req_ready); end
        @(posedge clk); #1;
        req_valid = '0;
        rst       = 1'b1;
        @(posedge clk);
        @(negedge clk);
        n_vec++;
        if (busy !== 1'b0 || rsp_valid !== 1'b0 || rsp_p !== 8'd0) begin
            n_miss++; $display("FAIL rstcalc_state: got busy%b v%b p %0d want busy0 v0 p 0", busy, rsp_valid, rsp_p);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            n_vec++;
            if (rsp_valid !== 1'b0 || rsp_p === 8'd63) begin
                n_miss++; $display("FAIL rstcalc_ghost: got v%b p %0d want v0 and no 63", rsp_valid, rsp_p);
            end
        end
    endtask

    task automatic test_wrap();
        do_reset();
        rsp_ready       = 1'b1;
        req_a[3*W +: W] = 4'd2;
        req_b[3*W +: W] = 4'd6;
        req_valid       = 4'b1000;
        @(negedge clk);
        n_vec++;
        if (req_ready !== 4'b1000) begin n_miss++; $display("FAIL wrap_first: got %b want 1000", req_ready); end
        @(posedge clk); #1;
        req_valid = '0;
        repeat (2) @(posedge clk);
        #1;
        req_a[1*W +: W] = 4'd0;
        req_b[1*W +: W] = 4'd13;
        req_a[3*W +: W] = 4'd5;
        req_b[3*W +: W] = 4'd5;
        req_valid       = 4'b1010;
        @(negedge clk);
        n_vec++;
        if (req_ready !== 4'b0010) begin n_miss++; $display("FAIL wrap_grant: got %b want 0010", req_ready); end
        @(posedge clk); #1;
        req_valid = '0;
        @(posedge clk);
        @(negedge clk);
        n_vec++;
        if (rsp_valid !== 1'b1 || rsp_id !== 2'd1 || rsp_p !== 8'd0) begin
            n_miss++; $display("FAIL wrap_zero: got v%b id %0d p %0d want v1 id 1 p 0", rsp_valid, rsp_id, rsp_p);
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 10000; c++) begin
            req_valid = NREQ'($urandom_range(0, (1 << NREQ) - 1));
            req_a     = (NREQ*W)'($urandom);
            req_b     = (NREQ*W)'($urandom);
            rsp_ready = ($urandom_range(0, 3) != 0);
            @(posedge clk); #1;
        end
        req_valid = '0;
        rsp_ready = 1'b1;
        repeat (4) @(posedge clk);
        @(negedge clk);
        n_vec++;
        if (busy !== 1'b0 || q_id.size() != 0) begin
            n_miss++; $display("FAIL random_drain: got busy%b pending %0d want busy0 pending 0", busy, q_id.size());
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_hold();
        test_rst_calc();
        test_wrap();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
